// File: rtl/actuator_sequencer.sv
// Actuator start sequencer with staggered, round-robin turn-ons and min-on/min-off timing.
// Each actuator has its own min-on and min-off timers. Grants happen one at a time,
// are spaced by the stagger interval, and are limited by MAX_ON. Turn-offs are immediate,
// and several may happen in the same cycle.
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   reset_n    - asynchronous active-low reset
//   req        - requested actuator enables (bit i -> actuator A(i+1))
//   emergency  - when high, a request may start without waiting out the min-off time
//   act_en     - registered actuator drive
//   pending    - combinational: requested, allowed by EN_MASK, but not yet driven
//   busy       - high while the controller waits out the stagger interval
//   last_grant - index of the most recently started actuator
module actuator_sequencer #(
    parameter int unsigned      N_ACT       = 6,
    parameter int unsigned      STAGGER_CYC = 16,
    parameter int unsigned      MIN_ON_CYC  = 64,
    parameter int unsigned      MIN_OFF_CYC = 64,
    parameter int unsigned      MAX_ON      = 6,
    parameter logic [N_ACT-1:0] EN_MASK     = 6'b111101
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_ACT-1:0] req,
    input  logic             emergency,
    output logic [N_ACT-1:0] act_en,
    output logic [N_ACT-1:0] pending,
    output logic             busy,
    output logic [2:0]       last_grant
);

    localparam int unsigned TMR_W = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = $clog2(N_ACT + 1);

    // A timer value of 0 lets the next edge act, so each timer is loaded with (cycles - 1).
    localparam logic [TMR_W-1:0] ON_LOAD   = TMR_W'(MIN_ON_CYC - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD  = TMR_W'(MIN_OFF_CYC - 1);
    // SETTLE lasts STAGGER_CYC-1 cycles, and the IDLE cycle after it is the next grant slot.
    localparam bit               STAG_EN   = (STAGGER_CYC > 1);
    localparam logic [TMR_W-1:0] STAG_LOAD = STAG_EN ? TMR_W'(STAGGER_CYC - 2) : '0;
    localparam logic [CNT_W-1:0] MAX_ON_C  = CNT_W'(MAX_ON);
    localparam logic [IDX_W-1:0] LG_RST    = IDX_W'(N_ACT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t                       state, state_nxt;
    logic [TMR_W-1:0]             stag_cnt, stag_nxt;
    logic [N_ACT-1:0]             act_nxt;
    logic [IDX_W-1:0]             lg_nxt;
    logic [N_ACT-1:0][TMR_W-1:0]  on_timer, on_nxt;
    logic [N_ACT-1:0][TMR_W-1:0]  off_timer, off_nxt;

    logic [CNT_W-1:0]             on_count;
    logic                         found_hi, found_lo;
    logic [IDX_W-1:0]             hi_idx, lo_idx, grant_idx;
    logic                         grant;

    // Eligibility, active count and round-robin pick.
    // The lowest eligible index above last_grant wins. If there is none, the search wraps
    // and the lowest eligible index overall wins.
    always_comb begin
        logic elig;
        on_count = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        elig     = 1'b0;
        for (int unsigned i = 0; i < N_ACT; i++) begin
            on_count = on_count + CNT_W'(act_en[i]);
            elig = req[i] & EN_MASK[i] & ~act_en[i] & ((off_timer[i] == '0) | emergency);
            if (elig) begin
                if (!found_lo) begin
                    found_lo = 1'b1;
                    lo_idx   = IDX_W'(i);
                end
                if (!found_hi && (IDX_W'(i) > last_grant)) begin
                    found_hi = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        grant_idx = found_hi ? hi_idx : lo_idx;
        grant     = (state == IDLE) && found_lo && (on_count < MAX_ON_C);
    end

    // Next-state logic for the FSM, the timers and the actuator drive.
    always_comb begin
        state_nxt = state;
        stag_nxt  = stag_cnt;
        act_nxt   = act_en;
        lg_nxt    = last_grant;
        on_nxt    = on_timer;
        off_nxt   = off_timer;

        for (int unsigned i = 0; i < N_ACT; i++) begin
            on_nxt[i]  = (on_timer[i] == '0) ? '0 : on_timer[i] - TMR_W'(1);
            off_nxt[i] = (off_timer[i] == '0) ? '0 : off_timer[i] - TMR_W'(1);
            // A turn-off needs the request dropped and the min-on time served.
            if (act_en[i] && !req[i] && (on_timer[i] == '0)) begin
                act_nxt[i] = 1'b0;
                off_nxt[i] = OFF_LOAD;
            end
            if (grant && (grant_idx == IDX_W'(i))) begin
                act_nxt[i] = 1'b1;
                on_nxt[i]  = ON_LOAD;
            end
        end

        if (grant) begin
            lg_nxt = grant_idx;
        end

        case (state)
            IDLE: begin
                if (grant && STAG_EN) begin
                    state_nxt = SETTLE;
                    stag_nxt  = STAG_LOAD;
                end
            end
            SETTLE: begin
                if (stag_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    stag_nxt = stag_cnt - TMR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            stag_cnt   <= '0;
            act_en     <= '0;
            last_grant <= LG_RST;
            on_timer   <= '0;
            off_timer  <= '0;
        end else begin
            state      <= state_nxt;
            stag_cnt   <= stag_nxt;
            act_en     <= act_nxt;
            last_grant <= lg_nxt;
            on_timer   <= on_nxt;
            off_timer  <= off_nxt;
        end
    end

    assign pending = req & EN_MASK & ~act_en;
    assign busy    = (state == SETTLE);

endmodule

// File: doc/actuator_sequencer.md
ACTUATOR_SEQUENCER -- requirements
Module: actuator_sequencer

Interface
REQ-001 SHALL have parameter N_ACT, default 6, number of actuators; bit i drives actuator A(i+1).
REQ-002 SHALL have parameter STAGGER_CYC, default 16, minimum cycles between consecutive turn-ons (1..255).
REQ-003 SHALL have parameter MIN_ON_CYC, default 64, minimum act_en high time in cycles (1..255).
REQ-004 SHALL have parameter MIN_OFF_CYC, default 64, minimum act_en low time after turn-off in cycles (1..255).
REQ-005 SHALL have parameter MAX_ON, default 6, maximum simultaneously enabled actuators (1..N_ACT).
REQ-006 SHALL have parameter EN_MASK, default 6'b111101, permanently disabled actuators have bit=0 (A2 inline duct fan off).
REQ-007 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-008 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port req  input  N_ACT  requested actuator enables from the environmental FSM.
REQ-010 SHALL have port emergency  input  1  high = bypass min-off hold-off.
REQ-011 SHALL have port act_en  output  N_ACT  registered actuator drive.
REQ-012 SHALL have port pending  output  N_ACT  req & EN_MASK & ~act_en, combinational.
REQ-013 SHALL have port busy  output  1  high while controller state is SETTLE.
REQ-014 SHALL have port last_grant  output  3  index of most recently started actuator.

Function
REQ-015 SHALL keep per-actuator on_timer and off_timer, 8 bits, saturating decrement to 0 each cycle.
REQ-016 SHALL treat actuator i eligible for start when req[i]=1, EN_MASK[i]=1, act_en[i]=0, and (off_timer[i]=0 or emergency=1).
REQ-017 SHALL implement controller FSM IDLE/SETTLE: IDLE->SETTLE on a grant; SETTLE->IDLE when stagger counter expires; grants only in IDLE.
REQ-018 SHALL grant at most one start per cycle, only when popcount(act_en) < MAX_ON, counted on current registered act_en.
REQ-019 SHALL pick the grant round-robin: first eligible index searching upward from last_grant+1, wrapping at N_ACT-1 to 0.
REQ-020 SHALL on grant set act_en[i]=1, last_grant=i, on_timer[i] so act_en[i] stays high >= MIN_ON_CYC cycles.
REQ-021 SHALL space consecutive grants exactly STAGGER_CYC cycles apart when eligible actuators remain continuously.
REQ-022 SHALL clear act_en[i] when req[i]=0 and on_timer[i]=0, loading off_timer[i] for a low time >= MIN_OFF_CYC cycles; turn-offs unstaggered, any number per cycle.
REQ-023 SHALL keep act_en[i] high if req[i] returns to 1 before on_timer[i] expires (no toggling).
REQ-024 SHALL drop a pending request that deasserts before grant with no side effect.
REQ-025 SHALL allow a turn-off and a grant in the same cycle; the freed slot counts toward MAX_ON only from the next cycle.
REQ-026 SHALL never assert act_en[i] where EN_MASK[i]=0, regardless of req or emergency.
REQ-027 SHALL not bypass stagger, MAX_ON or min-on timing with emergency.

Reset
REQ-028 SHALL on reset_n=0 immediately force act_en=0, busy=0, last_grant=N_ACT-1, FSM=IDLE, all timers=0.
REQ-029 SHALL after reset release grant first to index 0 if eligible; reset mid-sequence aborts it with no residual timers.

Verification
REQ-030 Reset: reset_n=0 with req=6'b111111 -> act_en=0, busy=0, last_grant=5 throughout.
REQ-031 Stagger: req=6'b111111 from idle, first grant edge T -> act_en bits 0,2,3,4,5 rise at T, T+16, T+32, T+48, T+64; bit1 never.
REQ-032 Min-on/off: 1-cycle req[0] pulse -> act_en[0] high exactly 64 cycles; req[0] held high after fall -> re-rise 64 cycles later.
REQ-033 Emergency: act_en[0] just fell, emergency=1, req[0]=1 -> act_en[0] rises next IDLE grant slot, not after 64 cycles.
REQ-034 MAX_ON=2, req=6'b111101 -> only bits 0,2 on; req[0] dropped after min-on -> bit3 granted one cycle after act_en[0] falls.
REQ-035 Reset mid-sequence: reset_n low during SETTLE after 2 grants -> act_en=0 at once; after release grant restarts at bit 0.
